// File: rtl/mole_spawner.sv
// mole_spawner: schedules mole spawns for the timer bank.
// Once per difficulty-dependent interval it picks a pseudo-random idle hole,
// pulses that hole's request line for one cycle with a 3-bit up-time code,
// and skips the spawn when too many moles are already up.
//
// Handshake: mole is a fire-and-forget strobe. Exactly one bit is high for
// exactly one cycle (the FIRE state). moletime is valid in that cycle and
// holds its value afterwards. There is no back-pressure from the timer bank.
module mole_spawner #(
    parameter int          TICK_DIV  = 100000,
    parameter int          INT0      = 1000,
    parameter int          INT1      = 700,
    parameter int          INT2      = 450,
    parameter int          INT3      = 250,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] difficulty,
    input  logic [7:0] omole,
    output logic [7:0] mole,
    output logic [2:0] moletime,
    output logic [7:0] spawn_count,
    output logic [2:0] state_dbg
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        PICK  = 3'd2,
        PROBE = 3'd3,
        FIRE  = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [15:0]      lfsr;
    logic [DIV_W-1:0] div, div_n;
    logic [15:0]      icnt, icnt_n;
    logic [15:0]      ilast, ilast_n;
    logic [15:0]      sel_last;
    logic [2:0]       idx, idx_n;
    logic [2:0]       tcode, tcode_n;
    logic [2:0]       probe, probe_n;
    logic [7:0]       mole_n;
    logic [2:0]       moletime_n;
    logic [7:0]       count_n;
    logic [3:0]       busy_cnt;
    logic [3:0]       cap;
    logic             tick;

    assign state_dbg = state;
    assign tick      = (state == WAIT) && (div == DIV_W'(TICK_DIV - 1));
    assign cap       = {2'b00, difficulty} + 4'd1;

    // Last interval count for the current difficulty; latched on WAIT entry.
    always_comb begin
        sel_last = 16'(INT0 - 1);
        case (difficulty)
            2'd0: sel_last = 16'(INT0 - 1);
            2'd1: sel_last = 16'(INT1 - 1);
            2'd2: sel_last = 16'(INT2 - 1);
            2'd3: sel_last = 16'(INT3 - 1);
            default: sel_last = 16'(INT0 - 1);
        endcase
    end

    // Number of moles currently up, compared against the concurrency cap.
    always_comb begin
        busy_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            busy_cnt = busy_cnt + {3'b000, omole[i]};
        end
    end

    // Free-running Fibonacci LFSR (taps 16,14,13,11); runs in every state.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Next-state and next-output logic; enable low overrides every state.
    always_comb begin
        state_n    = state;
        div_n      = div;
        icnt_n     = icnt;
        ilast_n    = ilast;
        idx_n      = idx;
        tcode_n    = tcode;
        probe_n    = probe;
        mole_n     = 8'h00;
        moletime_n = moletime;
        count_n    = spawn_count;
        if (!enable) begin
            state_n = IDLE;
            div_n   = '0;
            icnt_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = WAIT;
                    div_n   = '0;
                    icnt_n  = '0;
                    ilast_n = sel_last;
                end
                WAIT: begin
                    if (tick) begin
                        div_n = '0;
                        if (icnt == ilast) begin
                            state_n = PICK;
                            icnt_n  = '0;
                        end else begin
                            icnt_n = icnt + 16'd1;
                        end
                    end else begin
                        div_n = div + DIV_W'(1);
                    end
                end
                PICK: begin
                    idx_n   = lfsr[2:0];
                    tcode_n = lfsr[10:8];
                    probe_n = 3'd0;
                    if (busy_cnt >= cap) begin
                        // Too many moles up: give up this interval, no retry.
                        state_n = WAIT;
                        div_n   = '0;
                        icnt_n  = '0;
                        ilast_n = sel_last;
                    end else begin
                        state_n = PROBE;
                    end
                end
                PROBE: begin
                    if (!omole[idx]) begin
                        // Pulse and code are registered so they appear in FIRE.
                        state_n    = FIRE;
                        mole_n     = 8'h01 << idx;
                        moletime_n = tcode;
                        count_n    = spawn_count + 8'd1;
                    end else if (probe == 3'd7) begin
                        // Every hole busy; only reachable if omole moves under us.
                        state_n = WAIT;
                        div_n   = '0;
                        icnt_n  = '0;
                        ilast_n = sel_last;
                    end else begin
                        idx_n   = idx + 3'd1;
                        probe_n = probe + 3'd1;
                    end
                end
                FIRE: begin
                    state_n = WAIT;
                    div_n   = '0;
                    icnt_n  = '0;
                    ilast_n = sel_last;
                end
                default: begin
                    state_n = IDLE;
                    div_n   = '0;
                    icnt_n  = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs; reset dominates everything.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state       <= IDLE;
            div         <= '0;
            icnt        <= '0;
            ilast       <= 16'(INT0 - 1);
            idx         <= 3'd0;
            tcode       <= 3'd0;
            probe       <= 3'd0;
            mole        <= 8'h00;
            moletime    <= 3'd0;
            spawn_count <= 8'd0;
        end else begin
            state       <= state_n;
            div         <= div_n;
            icnt        <= icnt_n;
            ilast       <= ilast_n;
            idx         <= idx_n;
            tcode       <= tcode_n;
            probe       <= probe_n;
            mole        <= mole_n;
            moletime    <= moletime_n;
            spawn_count <= count_n;
        end
    end

endmodule

// File: tb/tb_mole_spawner.sv
// tb_mole_spawner: directed bench for mole_spawner with small timing
// parameters. Stimulus pushes each expected spawn (hole, up-time code,
// spawn count, cycle) into a queue; a monitor pops and compares whenever
// a pulse appears on mole.
module tb_mole_spawner;

    localparam int          TICK_DIV  = 4;
    localparam int          INT0      = 5;
    localparam int          INT1      = 4;
    localparam int          INT2      = 3;
    localparam int          INT3      = 2;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int          W         = 30;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PROBE = 3'd3;
    localparam logic [2:0] S_FIRE  = 3'd4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] difficulty;
    logic [7:0] omole;
    logic [7:0] mole;
    logic [2:0] moletime;
    logic [7:0] spawn_count;
    logic [2:0] state_dbg;

    // Expected entry: {fire cycle[29:14], count[13:6], moletime[5:3], hole[2:0]}
    logic [W-1:0] exp_q[$];
    int           n_vec  = 0;
    int           n_fail = 0;
    int           cyc    = 0;
    logic [15:0]  lfsr_m;
    logic [7:0]   count_exp = 8'd0;
    logic [7:0]   holes_hit = 8'h00;
    logic [7:0]   prev_mole = 8'h00;

    mole_spawner #(
        .TICK_DIV (TICK_DIV),
        .INT0     (INT0),
        .INT1     (INT1),
        .INT2     (INT2),
        .INT3     (INT3),
        .LFSR_SEED(LFSR_SEED)
    ) dut (
        .CLK100MHZ  (clk),
        .reset      (reset),
        .enable     (enable),
        .difficulty (difficulty),
        .omole      (omole),
        .mole       (mole),
        .moletime   (moletime),
        .spawn_count(spawn_count),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset / reference LFSR ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) lfsr_m = LFSR_SEED;
        else       lfsr_m = lfsr_step(lfsr_m);
    end

    function automatic logic [15:0] lfsr_ahead(input int n);
        logic [15:0] v;
        v = lfsr_m;
        for (int i = cyc; i < n; i++) v = lfsr_step(v);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go_idle();
        enable = 1'b0;
        wait_until(cyc + 1);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Push the spawn expected from a PICK at cycle p with omole held at om
    // through probing; returns the cycle in which the pulse must appear.
    task automatic plan(input int p, input logic [7:0] om, output int f);
        logic [15:0] v;
        logic [2:0]  idx;
        int          busy;
        v    = lfsr_ahead(p);
        idx  = v[2:0];
        busy = 0;
        while (om[idx] && busy < 8) begin
            idx  = idx + 3'd1;
            busy = busy + 1;
        end
        f = p + 2 + busy;
        count_exp = count_exp + 8'd1;
        exp_q.push_back({16'(f), count_exp, v[10:8], idx});
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] ent;
        if (mole !== 8'h00) begin
            holes_hit = holes_hit | mole;
            check("pulse_width", 32'(prev_mole), 32'h0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_pulse actual=%0h required=00 cyc=%0d", mole, cyc);
            end else begin
                ent = exp_q.pop_front();
                check("pulse_hole", 32'(mole), 32'(8'h01 << ent[2:0]));
                check("pulse_moletime", 32'(moletime), 32'(ent[5:3]));
                check("pulse_count", 32'(spawn_count), 32'(ent[13:6]));
                check("pulse_cycle", cyc, 32'(ent[29:14]));
            end
        end
        prev_mole = mole;
    end

    // ---------------- stimulus ----------------
    initial begin
        int          e;
        int          p;
        int          f;
        logic [15:0] v;
        logic [W-1:0] ent;

        reset      = 1'b1;
        enable     = 1'b1;
        difficulty = 2'd0;
        omole      = 8'h00;
        f          = 0;

        // Reset with enable high, then 100 idle cycles with enable low.
        wait_until(2);
        check("rst_mole", 32'(mole), 32'h0);
        check("rst_moletime", 32'(moletime), 32'h0);
        check("rst_count", 32'(spawn_count), 32'h0);
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        reset  = 1'b0;
        enable = 1'b0;
        wait_until(102);
        check("idle_state", 32'(state_dbg), 32'(S_IDLE));
        check("idle_count", 32'(spawn_count), 32'h0);

        // Basic cadence, difficulty 0: pulse 23 cycles after enable, then every 23.
        difficulty = 2'd0;
        omole      = 8'h00;
        e          = cyc;
        enable     = 1'b1;
        p          = e + 21;
        for (int k = 0; k < 4; k++) begin
            plan(p, 8'h00, f);
            p = f + 21;
        end
        wait_until(f + 1);
        check("cadence_count", 32'(spawn_count), 32'd4);
        go_idle();

        // Probing: LFSR gives idx 3 in PICK, holes 1..7 go busy from PROBE on.
        e = cyc + 1;
        v = lfsr_ahead(e + 21);
        while (v[2:0] != 3'd3 && e < cyc + 400) begin
            e = e + 1;
            v = lfsr_ahead(e + 21);
        end
        if (v[2:0] != 3'd3) begin
            n_vec++;
            n_fail++;
            $display("FAIL probe_setup actual=%0h required=3", v[2:0]);
        end
        wait_until(e);
        enable = 1'b1;
        p = e + 21;
        plan(p, 8'hFE, f);
        wait_until(p + 1);
        omole = 8'hFE;
        wait_until(p + 7);
        check("probe_fire_state", 32'(state_dbg), 32'(S_FIRE));
        check("probe_hole0", 32'(mole), 32'h01);
        wait_until(p + 8);
        omole = 8'h00;
        go_idle();

        // Cap/skip: difficulty 1 (cap 2) with two moles up skips 10 intervals.
        difficulty = 2'd1;
        omole      = 8'h11;
        e          = cyc;
        enable     = 1'b1;
        p          = e + 17;
        wait_until(p + 9 * 17 + 5);
        check("cap_count_held", 32'(spawn_count), 32'd5);
        omole = 8'h01;
        p = p + 10 * 17;
        plan(p, 8'h01, f);
        wait_until(f);
        check("cap_not_bit0", 32'(mole[0]), 32'h0);
        check("cap_pulsed", 32'(mole != 8'h00), 32'h1);
        wait_until(f + 1);
        go_idle();

        // Abort in PROBE: no pulse, IDLE next; re-enable waits a full interval.
        difficulty = 2'd0;
        omole      = 8'h00;
        e          = cyc;
        enable     = 1'b1;
        p          = e + 21;
        wait_until(p + 1);
        check("abort_in_probe", 32'(state_dbg), 32'(S_PROBE));
        enable = 1'b0;
        wait_until(p + 2);
        check("abort_idle", 32'(state_dbg), 32'(S_IDLE));
        check("abort_count", 32'(spawn_count), 32'd6);
        e      = cyc;
        enable = 1'b1;
        plan(e + 21, 8'h00, f);
        wait_until(f + 1);
        go_idle();

        // Sweep: 300 spawns at difficulty 3 wrap spawn_count and hit every hole.
        difficulty = 2'd3;
        omole      = 8'h00;
        holes_hit  = 8'h00;
        e          = cyc;
        enable     = 1'b1;
        p          = e + 9;
        for (int k = 0; k < 300; k++) begin
            plan(p, 8'h00, f);
            p = f + 9;
        end
        wait_until(f + 1);
        go_idle();
        check("sweep_holes", 32'(holes_hit), 32'hFF);
        check("final_count", 32'(spawn_count), 32'd51);

        // Any expectation still queued is a missing pulse.
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) wait_until(cyc + 1);
        while (exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            n_vec++;
            n_fail++;
            $display("FAIL missing_pulse actual=none required_cycle=%0d", ent[29:14]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
